ram_stream_reader: RTL
======================

// Module: ram_stream_reader
// PURPOSE
//  Read-side engine for the sample capture RAM (1-cycle registered read address, dualram_rdreg style).
//  On a start command it reads i_len words from i_base_addr, wrapping modulo RAM depth.
//  It emits them as a valid/ready stream toward the host/USB framer.
//  It hides the RAM read latency and absorbs backpressure with a 2-entry skid buffer; no word is lost or duplicated.
// PARAMETERS
//  ASIZE   13  RAM address width; depth = 1<<ASIZE
//  DSIZE    8  sample/data width
// PORTS
//  i_clk         in   1        system clock; all logic on posedge
//  i_rst         in   1        synchronous, active-high reset
//  i_start       in   1        start pulse; sampled only in IDLE
//  i_base_addr   in   ASIZE    first RAM address; latched on accepted start
//  i_len         in   ASIZE+1  word count, 0..1<<ASIZE; latched on accepted start
//  o_rd_addr     out  ASIZE    RAM read address (RAM registers it; data valid next cycle)
//  i_rd_data     in   DSIZE    RAM q
//  o_valid       out  1        stream word valid
//  o_data        out  DSIZE    stream word
//  o_last        out  1        qualifies final word of the burst (with o_valid)
//  i_ready       in   1        downstream accept; transfer = o_valid & i_ready
//  o_busy        out  1        high from accepted start until done
//  o_done        out  1        1-cycle pulse after the last transfer
// BEHAVIOUR
//  Reset: state IDLE; o_valid=0, o_last=0, o_busy=0, o_done=0, o_rd_addr=0, o_data=0; skid emptied; in-flight read discarded.
//  FSM: IDLE -(i_start & i_len!=0)-> RUN -(all i_len reads issued)-> DRAIN -(last word transferred)-> IDLE (o_done=1).
//  IDLE with i_start & i_len==0: stay IDLE, pulse o_done next cycle, o_busy stays 0.
//  i_start while o_busy: ignored; latched base/len unchanged.
//  Read issue: at most one read per cycle.
//    A read is issued only if (skid count + reads in flight) < 2 after this cycle's pop; guarantees no overflow.
//    o_rd_addr increments by 1 per issued read; wraps (1<<ASIZE)-1 -> 0.
//    i_len = 1<<ASIZE reads every location exactly once.
//  Latency: start sampled at cycle 0 -> o_valid first high at cycle 3. With i_ready held 1, one word per cycle thereafter.
//    Burst of N words: last transfer at cycle N+2; o_done at cycle N+3.
//  Ordering: words appear strictly in address order. o_data/o_valid/o_last are held stable while o_valid & !i_ready.
//  o_last: high exactly on the word whose remaining count is 1; otherwise 0.
//  Counters: issue counter and transfer counter are each ASIZE+1 bits; done is decided by the transfer counter reaching i_len.
//  Mid-burst i_rst: all state cleared on that edge; no o_done; the next start behaves as from power-up.
// CONFIGURATION
//  READER_CHKSUM_EN defined: adds output o_chksum [DSIZE+ASIZE-1:0].
//    o_chksum = unsigned sum of all transferred words in the current burst.
//    Cleared on accepted start; final value valid in the o_done cycle and held until the next start; reset 0.
//  Not defined: port absent, no adder logic.
// STRUCTURE
//  Package rsr_pkg: FSM state typedef (IDLE, RUN, DRAIN); SKID_DEPTH=2 constant.
//  Sub-module rsr_skid2: 2-entry FIFO carrying {last,data}, with push/pop/count.
//    Registered outputs; push and pop in the same cycle are allowed when count is 1 or 2.
//  Top level holds the FSM, address/issue/transfer counters, in-flight flag and the optional checksum.
// TESTING
//  1. ASIZE=4; RAM[i]=i; start base=3 len=5, ready=1 -> data 3,4,5,6,7 on cycles 3..7; o_last on 7; o_done cycle 8.
//  2. base=14 len=4 -> data 14,15,0,1 (wrap); len=16, base=0 -> all 16 locations once, then o_done.
//  3. len=6 with i_ready toggling 1,0,0,1,0,1... -> exactly 6 transfers in order; no drop or duplicate; data stable while stalled.
//  4. len=0 start -> o_busy stays 0, o_done pulses once, o_valid never high; start during busy -> ignored, burst completes unchanged.
//  5. i_rst asserted after 2 of 8 words -> next cycle all outputs at reset values; restart base=0 len=2 -> 0,1 and o_done.
//  6. READER_CHKSUM_EN, RAM[i]=0xFF, len=16 -> o_chksum=0xFF0 at o_done; without macro, build has no o_chksum port.

Source files
------------

// File: rtl/rsr_pkg.sv
// Shared types for the capture-RAM stream reader: FSM states and skid sizing.
// Latency: none (declarations only).
// Backpressure: n/a.
package rsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rsr_state_t;

  // Skid depth of 2 covers the single RAM read in flight plus one held word.
  localparam int SKID_DEPTH = 2;
  localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);

  typedef logic [SKID_CW-1:0] skid_cnt_t;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Output stream bundle of the capture-RAM reader toward the host framer.
// Latency: none (wires only).
// Backpressure: transfer happens when o_valid & i_ready; master holds its word while stalled.
interface ram_stream_reader_if #(
  parameter int DSIZE = 8
);
  logic             o_valid;
  logic [DSIZE-1:0] o_data;
  logic             o_last;
  logic             i_ready;

  modport master (output o_valid, output o_data, output o_last, input i_ready);
  modport slave  (input o_valid, input o_data, input o_last, output i_ready);
endinterface

// File: rtl/rsr_skid2.sv
// Two-entry FIFO with registered outputs, carrying {last,data} words.
// Latency: a push into an empty FIFO is visible on dout the next cycle.
// Backpressure: simultaneous push/pop allowed with 1 or 2 entries; caller must never push when full.
module rsr_skid2
  import rsr_pkg::*;
#(
  parameter int W = 9
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      push,
  input  logic      pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output skid_cnt_t count
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  skid_cnt_t    cnt_q;

  // Head is the word on offer; tail shifts into head on pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == skid_cnt_t'(0)) head_q <= din;
          else                         tail_q <= din;
          cnt_q <= cnt_q + skid_cnt_t'(1);
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - skid_cnt_t'(1);
        end
        2'b11: begin
          if (cnt_q == skid_cnt_t'(1)) begin
            head_q <= din;
          end else begin
            head_q <= tail_q;
            tail_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = head_q;
  assign count = cnt_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Reads i_len words from the capture RAM starting at i_base_addr (wrapping) and streams them out.
// Latency: start sampled in cycle 0 -> first o_valid in cycle 3; o_done one cycle after the last transfer.
// Backpressure: 2-entry skid absorbs i_ready stalls; reads are throttled so nothing is dropped. Optional READER_CHKSUM_EN adds o_chksum.
module ram_stream_reader
  import rsr_pkg::*;
#(
  parameter int ASIZE = 13,
  parameter int DSIZE = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [ASIZE-1:0] i_base_addr,
  input  logic [ASIZE:0]   i_len,
  output logic [ASIZE-1:0] o_rd_addr,
  input  logic [DSIZE-1:0] i_rd_data,
  output logic             o_busy,
  output logic             o_done,
`ifdef READER_CHKSUM_EN
  output logic [DSIZE+ASIZE-1:0] o_chksum,
`endif
  ram_stream_reader_if.master strm
);

  localparam logic [ASIZE:0]   CNT_ONE  = {{ASIZE{1'b0}}, 1'b1};
  localparam logic [ASIZE-1:0] ADDR_ONE = {{(ASIZE-1){1'b0}}, 1'b1};

  rsr_state_t       state_q, state_d;
  logic [ASIZE-1:0] addr_q;
  logic [ASIZE:0]   len_q;
  logic [ASIZE:0]   issue_cnt_q;
  logic [ASIZE:0]   xfer_cnt_q;
  logic             infl_q;
  logic             infl_last_q;
  logic             done_q;

  skid_cnt_t        skid_cnt;
  logic [DSIZE:0]   skid_out;
  logic [SKID_CW:0] occ;
  logic             room;
  logic             pop;
  logic             issue;
  logic             issue_last;
  logic             last_xfer;
  logic             start_ok;
  logic             start_zero;
  logic             done_d;

  assign pop        = strm.o_valid & strm.i_ready;
  assign issue_last = (issue_cnt_q + CNT_ONE) == len_q;
  assign last_xfer  = pop && ((xfer_cnt_q + CNT_ONE) == len_q);

  // Occupancy after this cycle's pop, counting the word already on the RAM output.
  assign occ  = {1'b0, skid_cnt} + {{SKID_CW{1'b0}}, infl_q} - {{SKID_CW{1'b0}}, pop};
  assign room = occ < (SKID_CW + 1)'(SKID_DEPTH);

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, read issue and done decision.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    start_ok   = 1'b0;
    start_zero = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            start_ok = 1'b1;
            state_d  = ST_RUN;
          end else begin
            start_zero = 1'b1;
            done_d     = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (room && (issue_cnt_q != len_q)) begin
          issue = 1'b1;
          if (issue_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_xfer) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address, counters, in-flight tracking and done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      xfer_cnt_q  <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= done_d;
      infl_q      <= issue;
      infl_last_q <= issue & issue_last;
      if (start_ok) begin
        addr_q      <= i_base_addr;
        len_q       <= i_len;
        issue_cnt_q <= '0;
        xfer_cnt_q  <= '0;
      end else begin
        if (issue) begin
          addr_q      <= addr_q + ADDR_ONE;
          issue_cnt_q <= issue_cnt_q + CNT_ONE;
        end
        if (pop) xfer_cnt_q <= xfer_cnt_q + CNT_ONE;
      end
    end
  end

  rsr_skid2 #(.W(DSIZE + 1)) u_skid (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (infl_q),
    .pop   (pop),
    .din   ({infl_last_q, i_rd_data}),
    .dout  (skid_out),
    .count (skid_cnt)
  );

  assign strm.o_valid = (skid_cnt != '0);
  assign strm.o_data  = skid_out[DSIZE-1:0];
  assign strm.o_last  = skid_out[DSIZE] & strm.o_valid;
  assign o_rd_addr    = addr_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = done_q;

`ifdef READER_CHKSUM_EN
  logic [DSIZE+ASIZE-1:0] chksum_q;

  // Running sum of transferred words; cleared when a start is taken in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst)                       chksum_q <= '0;
    else if (start_ok || start_zero) chksum_q <= '0;
    else if (pop)                    chksum_q <= chksum_q + {{ASIZE{1'b0}}, strm.o_data};
  end

  assign o_chksum = chksum_q;
`endif

endmodule
